// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch (I) and load/store (D) requesters onto one downstream memory port,
// running one outstanding transaction at a time and routing the response back to its owner.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  input  logic        i_cancel,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [63:0] i_data,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [63:0] d_data,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [63:0] m_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t         state_r;
  logic           owner_d_r;
  logic           drop_r;
  logic [SW-1:0]  d_streak_r;
  logic           m_valid_r;
  logic [31:0]    m_addr_r;
  logic           m_write_r;
  logic [1:0]     m_size_r;
  logic [7:0]     m_strobe_r;
  logic [63:0]    m_wdata_r;

  logic           i_elig_s;
  logic           grant_i_s;
  logic           grant_d_s;
  logic           resp_s;

  // Grant decision in IDLE; D wins ties until it has starved I for STARVE_LIMIT grants
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    i_elig_s  = i_valid && !i_cancel;
    if (resetn && (state_r == IDLE)) begin
      if (d_valid && i_elig_s) begin
        if (d_streak_r == SW'(STARVE_LIMIT)) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b1;
        end
      end else if (d_valid) begin
        grant_d_s = 1'b1;
      end else if (i_elig_s) begin
        grant_i_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
      end
    end else begin
      grant_d_s = 1'b0;
    end
  end

  // Response completes either in REQ (accept and data together) or later in WAIT
  always_comb begin
    resp_s = 1'b0;
    if (resetn && m_data_ok) begin
      resp_s = ((state_r == REQ) && m_addr_ok) || (state_r == WAIT);
    end else begin
      resp_s = 1'b0;
    end
  end

  assign i_addr_ok = grant_i_s;
  assign d_addr_ok = grant_d_s;
  assign i_data_ok = resp_s && !owner_d_r && !drop_r;
  assign d_data_ok = resp_s && owner_d_r;
  assign i_data    = m_data;
  assign d_data    = m_data;
  assign m_valid   = m_valid_r;
  assign m_addr    = m_addr_r;
  assign m_write   = m_write_r;
  assign m_size    = m_size_r;
  assign m_strobe  = m_strobe_r;
  assign m_wdata   = m_wdata_r;

  // Transaction FSM, payload latch, cancel tracking and starvation counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= IDLE;
      owner_d_r  <= 1'b0;
      drop_r     <= 1'b0;
      d_streak_r <= '0;
      m_valid_r  <= 1'b0;
      m_addr_r   <= 32'd0;
      m_write_r  <= 1'b0;
      m_size_r   <= 2'd0;
      m_strobe_r <= 8'd0;
      m_wdata_r  <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            state_r    <= REQ;
            owner_d_r  <= 1'b1;
            drop_r     <= 1'b0;
            m_valid_r  <= 1'b1;
            m_addr_r   <= d_addr;
            m_write_r  <= d_write;
            m_size_r   <= d_size;
            m_strobe_r <= d_strobe;
            m_wdata_r  <= d_wdata;
            if (!i_valid) begin
              d_streak_r <= '0;
            end else if (d_streak_r != SW'(STARVE_LIMIT)) begin
              d_streak_r <= d_streak_r + SW'(1);
            end else begin
              d_streak_r <= d_streak_r;
            end
          end else if (grant_i_s) begin
            state_r    <= REQ;
            owner_d_r  <= 1'b0;
            drop_r     <= 1'b0;
            m_valid_r  <= 1'b1;
            m_addr_r   <= i_addr;
            m_write_r  <= 1'b0;
            m_size_r   <= 2'd3;
            m_strobe_r <= 8'd0;
            m_wdata_r  <= 64'd0;
            d_streak_r <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (i_cancel && !owner_d_r) begin
            drop_r <= 1'b1;
          end
          if (m_addr_ok) begin
            m_valid_r <= 1'b0;
            if (m_data_ok) begin
              state_r <= IDLE;
              drop_r  <= 1'b0;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_cancel && !owner_d_r) begin
            drop_r <= 1'b1;
          end
          if (m_data_ok) begin
            state_r <= IDLE;
            drop_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          m_valid_r <= 1'b0;
          drop_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule
